// File: rtl/io_confirm_ctrl.sv
// -----------------------------------------------------------------------------
// io_confirm_ctrl
//
// Board-I/O front end for the CPU. An input request stalls the CPU until the
// operator gives a fresh press of the confirm button. The switches are then
// captured, zero- or sign-extended to CPU width and returned with a one-cycle
// valid pulse. Independently, a CPU-written output value is held for display.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous, active-high reset
//   confirm   in   raw, asynchronous, bouncing push-button
//   din       in   raw switch inputs (DIN_W), quasi-static
//   rd_req    in   CPU input request, only accepted in IDLE
//   rd_sext   in   extension mode latched with rd_req (1 = sign, 0 = zero)
//   stall     out  CPU hold while an input request is outstanding
//   rd_valid  out  one-cycle pulse: rd_data holds a new capture
//   rd_data   out  last captured, extended switch value (DOUT_W)
//   wr_en     in   CPU output write strobe
//   wr_data   in   CPU output value (DOUT_W)
//   dout      out  registered output value (DOUT_W)
// -----------------------------------------------------------------------------
module io_confirm_ctrl #(
   parameter int DIN_W      = 16,
   parameter int DOUT_W     = 32,
   parameter int DEB_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              confirm,
   input  logic [DIN_W-1:0]  din,
   input  logic              rd_req,
   input  logic              rd_sext,
   output logic              stall,
   output logic              rd_valid,
   output logic [DOUT_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic [DOUT_W-1:0] wr_data,
   output logic [DOUT_W-1:0] dout
);

   localparam int CNT_W = $clog2(DEB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_REL   = 2'd1,
      WAIT_PRESS = 2'd2,
      DONE       = 2'd3
   } state_t;

   // Widen the captured switches; the upper bits are either zero or copies
   // of the switch MSB. When DIN_W == DOUT_W the value passes unchanged.
   function automatic logic [DOUT_W-1:0] extend_din(input logic [DIN_W-1:0] v,
                                                    input logic sext);
      logic [DOUT_W-1:0] r;
      r = {DOUT_W{sext & v[DIN_W-1]}};
      r[DIN_W-1:0] = v;
      return r;
   endfunction

   logic              sync1_r;
   logic              sync2_r;
   logic [DIN_W-1:0]  din_r;
   logic [CNT_W-1:0]  cnt_r;
   logic              db_r;
   logic              db_q_r;
   logic              mode_r;
   logic              rd_valid_r;
   logic [DOUT_W-1:0] rd_data_r;
   logic [DOUT_W-1:0] dout_r;
   state_t            state_r;
   state_t            state_s;
   logic              press_s;
   logic              latch_mode_s;
   logic              capture_s;
   logic              stall_s;

   // Two-flop synchroniser for the button and a single register stage for the switches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         din_r   <= '0;
      end else begin
         sync1_r <= confirm;
         sync2_r <= sync1_r;
         din_r   <= din;
      end
   end

   // Debounce: db follows sync2 only after DEB_CYCLES consecutive differing
   // cycles; any return to equality restarts the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r  <= '0;
         db_r   <= 1'b0;
         db_q_r <= 1'b0;
      end else begin
         db_q_r <= db_r;
         if (sync2_r == db_r) begin
            cnt_r <= '0;
         end else if (cnt_r == CNT_LAST) begin
            db_r  <= sync2_r;
            cnt_r <= '0;
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
      end
   end

   assign press_s = db_r & ~db_q_r;

   // FSM next-state and control decode.
   always_comb begin
      state_s      = state_r;
      latch_mode_s = 1'b0;
      capture_s    = 1'b0;
      stall_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (rd_req) begin
               latch_mode_s = 1'b1;
               stall_s      = 1'b1;
               // A button already down at request time must be released first.
               if (db_r) begin
                  state_s = WAIT_REL;
               end else begin
                  state_s = WAIT_PRESS;
               end
            end else begin
               state_s = IDLE;
            end
         end
         WAIT_REL: begin
            stall_s = 1'b1;
            if (!db_r) begin
               state_s = WAIT_PRESS;
            end else begin
               state_s = WAIT_REL;
            end
         end
         WAIT_PRESS: begin
            stall_s = 1'b1;
            if (press_s) begin
               capture_s = 1'b1;
               state_s   = DONE;
            end else begin
               state_s = WAIT_PRESS;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // FSM state, latched extension mode and registered read outputs.
   // rd_valid is set on the capture edge so it is high exactly while in DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         mode_r     <= 1'b0;
         rd_valid_r <= 1'b0;
         rd_data_r  <= '0;
      end else begin
         state_r    <= state_s;
         rd_valid_r <= capture_s;
         if (latch_mode_s) begin
            mode_r <= rd_sext;
         end
         if (capture_s) begin
            rd_data_r <= extend_din(din_r, mode_r);
         end
      end
   end

   // Output display register, independent of the read FSM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_r <= '0;
      end else if (wr_en) begin
         dout_r <= wr_data;
      end
   end

   // stall is combinational so the CPU holds on the request cycle itself.
   assign stall    = stall_s;
   assign rd_valid = rd_valid_r;
   assign rd_data  = rd_data_r;
   assign dout     = dout_r;

endmodule

// File: tb/tb_io_confirm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_io_confirm_ctrl
//
// Directed bench for io_confirm_ctrl with DEB_CYCLES=4, DIN_W=16, DOUT_W=32.
// Inputs are driven 1 time unit after each rising edge and outputs sampled
// at the same point, so a value driven before edge E is seen by the DUT at E.
// With confirm first sampled at E0 and held, rd_valid is expected after E6,
// i.e. on the 7th tick after confirm is raised.
// -----------------------------------------------------------------------------
module tb_io_confirm_ctrl;

   localparam int DIN_W  = 16;
   localparam int DOUT_W = 32;
   localparam int DEB    = 4;
   localparam int LAT    = DEB + 3;

   logic              clk;
   logic              rst;
   logic              confirm;
   logic [DIN_W-1:0]  din;
   logic              rd_req;
   logic              rd_sext;
   logic              stall;
   logic              rd_valid;
   logic [DOUT_W-1:0] rd_data;
   logic              wr_en;
   logic [DOUT_W-1:0] wr_data;
   logic [DOUT_W-1:0] dout;

   int checks = 0;
   int errors = 0;
   int n;
   int early;
   int v;

   io_confirm_ctrl #(
      .DIN_W      (DIN_W),
      .DOUT_W     (DOUT_W),
      .DEB_CYCLES (DEB)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .confirm  (confirm),
      .din      (din),
      .rd_req   (rd_req),
      .rd_sext  (rd_sext),
      .stall    (stall),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .dout     (dout)
   );

   // 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Tick until rd_valid (bounded); count ticks and cycles where stall dropped early.
   task automatic run_until_valid(input int maxc, output int cnt, output int drops);
      cnt   = 0;
      drops = 0;
      do begin
         tick();
         cnt++;
         if (!rd_valid && !stall) drops++;
      end while (!rd_valid && cnt < maxc);
   endtask

   // Tick a fixed number of cycles and count rd_valid pulses.
   task automatic count_valid(input int cycles, output int pulses);
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (rd_valid) pulses++;
      end
   endtask

   task automatic request(input logic [DIN_W-1:0] sw, input logic sext);
      din     = sw;
      rd_req  = 1'b1;
      rd_sext = sext;
      #1;
      check("stall_on_req_cycle", 32'(stall), 32'd1);
      tick();
      rd_req  = 1'b0;
   endtask

   initial begin
      rst     = 1'b1;
      confirm = 1'b0;
      din     = 16'h0000;
      rd_req  = 1'b0;
      rd_sext = 1'b0;
      wr_en   = 1'b0;
      wr_data = 32'h0;
      tick();
      tick();
      check("rst_stall",    32'(stall),    32'd0);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_rd_data",  rd_data,       32'h0);
      check("rst_dout",     dout,          32'h0);
      rst = 1'b0;
      tick();

      // Basic read: zero-extend 0x0002.
      request(16'h0002, 1'b0);
      check("basic_stall_wait", 32'(stall), 32'd1);
      confirm = 1'b1;
      run_until_valid(20, n, early);
      check("basic_latency",  32'(n),        32'(LAT));
      check("basic_no_early", 32'(early),    32'd0);
      check("basic_valid",    32'(rd_valid), 32'd1);
      check("basic_data",     rd_data,       32'h00000002);
      check("basic_stall_done", 32'(stall),  32'd0);
      tick();
      check("basic_valid_single", 32'(rd_valid), 32'd0);
      check("basic_data_hold",    rd_data,       32'h00000002);
      confirm = 1'b0;
      repeat (8) tick();

      // Reset in the middle of a request.
      wr_en   = 1'b1;
      wr_data = 32'h00000005;
      tick();
      wr_en   = 1'b0;
      check("dout_load", dout, 32'h00000005);
      request(16'h0003, 1'b0);
      check("pre_rst_stall", 32'(stall), 32'd1);
      rst = 1'b1;
      #1;
      check("midrst_stall",    32'(stall),    32'd0);
      check("midrst_rd_valid", 32'(rd_valid), 32'd0);
      check("midrst_rd_data",  rd_data,       32'h0);
      check("midrst_dout",     dout,          32'h0);
      tick();
      rst = 1'b0;
      tick();
      confirm = 1'b1;
      count_valid(12, v);
      check("press_no_req_valid", 32'(v),     32'd0);
      check("press_no_req_stall", 32'(stall), 32'd0);
      confirm = 1'b0;
      repeat (8) tick();

      // Bouncing button: 1,1,0,1,0 then steady 1.
      request(16'h1234, 1'b0);
      v = 0;
      confirm = 1'b1; tick(); if (rd_valid) v++;
      confirm = 1'b1; tick(); if (rd_valid) v++;
      confirm = 1'b0; tick(); if (rd_valid) v++;
      confirm = 1'b1; tick(); if (rd_valid) v++;
      confirm = 1'b0; tick(); if (rd_valid) v++;
      check("bounce_no_early", 32'(v), 32'd0);
      confirm = 1'b1;
      run_until_valid(20, n, early);
      check("bounce_latency", 32'(n),   32'(LAT));
      check("bounce_data",    rd_data,  32'h00001234);
      count_valid(4, v);
      check("bounce_single", 32'(v), 32'd0);
      confirm = 1'b0;
      repeat (8) tick();

      // Button already held at request time.
      confirm = 1'b1;
      repeat (8) tick();
      request(16'h0001, 1'b0);
      count_valid(10, v);
      check("held_no_capture", 32'(v),     32'd0);
      check("held_stall",      32'(stall), 32'd1);
      confirm = 1'b0;
      count_valid(6, v);
      check("held_release_no_capture", 32'(v), 32'd0);
      confirm = 1'b1;
      run_until_valid(20, n, early);
      check("held_latency", 32'(n), 32'(LAT));
      check("held_data",    rd_data, 32'h00000001);
      count_valid(4, v);
      check("held_single", 32'(v), 32'd0);
      confirm = 1'b0;
      repeat (8) tick();

      // Sign-extend, with rd_sext flipped after the request cycle.
      request(16'h8001, 1'b1);
      rd_sext = 1'b0;
      confirm = 1'b1;
      run_until_valid(20, n, early);
      check("sext_latency", 32'(n), 32'(LAT));
      check("sext_data",    rd_data, 32'hFFFF8001);
      confirm = 1'b0;
      repeat (8) tick();

      // Zero-extend, with rd_sext flipped after the request cycle.
      request(16'h8001, 1'b0);
      rd_sext = 1'b1;
      confirm = 1'b1;
      run_until_valid(20, n, early);
      check("zext_latency", 32'(n), 32'(LAT));
      check("zext_data",    rd_data, 32'h00008001);
      confirm = 1'b0;
      rd_sext = 1'b0;
      repeat (8) tick();

      // Concurrency: second request ignored, write in the capture cycle.
      request(16'h00F0, 1'b0);
      confirm = 1'b1;
      tick(); tick(); tick();
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      tick(); tick();
      check("conc_no_early", 32'(rd_valid), 32'd0);
      wr_en   = 1'b1;
      wr_data = 32'hDEADBEEF;
      tick();
      wr_en   = 1'b0;
      check("conc_valid", 32'(rd_valid), 32'd1);
      check("conc_data",  rd_data,       32'h000000F0);
      check("conc_dout",  dout,          32'hDEADBEEF);
      tick();
      check("conc_idle_stall", 32'(stall), 32'd0);
      confirm = 1'b0;
      repeat (8) tick();
      confirm = 1'b1;
      count_valid(12, v);
      check("conc_no_queued_req", 32'(v),     32'd0);
      check("conc_stall_after",   32'(stall), 32'd0);
      check("conc_dout_hold",     dout,       32'hDEADBEEF);
      check("conc_data_hold",     rd_data,    32'h000000F0);
      confirm = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
